sobel_frame_loader: RTL and testbench



---
 rtl/sobel_frame_loader_if.sv | 10 +
 rtl/sobel_frame_loader.sv | 113 +++++++++++
 tb/tb_sobel_frame_loader.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/sobel_frame_loader_if.sv
// Pixel stream handshake between a raster source and the sobel frame loader.
interface sobel_frame_loader_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/sobel_frame_loader.sv
// Stores one raster-order pixel frame into the sobel indata memory at {Y,X},
// then holds sobel ap_start until ap_done and reports frame completion.
module sobel_frame_loader #(
  parameter int unsigned IMG_W   = 512,
  parameter int unsigned IMG_H   = 512,
  parameter int unsigned COORD_W = 9
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  sobel_frame_loader_if.slave    s,
  output logic [2*COORD_W-1:0]   mem_address0,
  output logic                   mem_ce0,
  output logic                   mem_we0,
  output logic [7:0]             mem_d0,
  output logic                   sobel_start,
  input  logic                   sobel_done,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   line_err,
  output logic [15:0]            frame_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_H - 1);

  logic [1:0]         state, state_nxt;
  logic [COORD_W-1:0] x, y, x_nxt, y_nxt;
  logic               accept;
  logic               x_last;

  // Ready is a pure state decode, forced low while reset is held.
  assign s.tready    = ~ap_rst & ((state == S_IDLE) | (state == S_LOAD));
  assign accept      = s.tvalid & s.tready;
  assign x_last      = (x == X_LAST);

  assign sobel_start = (state == S_RUN);
  assign busy        = (state != S_IDLE);
  assign frame_done  = (state == S_DONE);

  // x/y are always zero in IDLE, so IDLE and LOAD share the addressing path.
  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    case (state)
      S_IDLE, S_LOAD: begin
        if (accept) begin
          state_nxt = S_LOAD;
          if (x_last) begin
            x_nxt = '0;
            if (y == Y_LAST) begin
              y_nxt     = '0;
              state_nxt = S_RUN;
            end else begin
              y_nxt = y + COORD_W'(1);
            end
          end else begin
            x_nxt = x + COORD_W'(1);
          end
        end
      end
      S_RUN:   if (sobel_done) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state <= S_IDLE;
      x     <= '0;
      y     <= '0;
    end else begin
      state <= state_nxt;
      x     <= x_nxt;
      y     <= y_nxt;
    end
  end

  // Memory write port lags acceptance by one cycle; address/data hold when idle.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      mem_ce0      <= 1'b0;
      mem_we0      <= 1'b0;
      mem_address0 <= '0;
      mem_d0       <= '0;
    end else begin
      mem_ce0 <= accept;
      mem_we0 <= accept;
      if (accept) begin
        mem_address0 <= {y, x};
        mem_d0       <= s.tdata;
      end
    end
  end

  // tlast must coincide with the last column; a mismatch is sticky until reset.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      line_err  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (accept && (s.tlast != x_last)) line_err <= 1'b1;
      if ((state == S_RUN) && sobel_done) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_sobel_frame_loader.sv
// Directed bench for sobel_frame_loader on a 4x2 frame.
module tb_sobel_frame_loader;
  localparam int unsigned IMG_W   = 4;
  localparam int unsigned IMG_H   = 2;
  localparam int unsigned COORD_W = 3;

  logic                  ap_clk = 1'b0;
  logic                  ap_rst;
  logic [2*COORD_W-1:0]  mem_address0;
  logic                  mem_ce0, mem_we0;
  logic [7:0]            mem_d0;
  logic                  sobel_start, sobel_done, busy, frame_done, line_err;
  logic [15:0]           frame_cnt;

  sobel_frame_loader_if s_if ();

  sobel_frame_loader #(.IMG_W(IMG_W), .IMG_H(IMG_H), .COORD_W(COORD_W)) dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .s           (s_if),
    .mem_address0(mem_address0),
    .mem_ce0     (mem_ce0),
    .mem_we0     (mem_we0),
    .mem_d0      (mem_d0),
    .sobel_start (sobel_start),
    .sobel_done  (sobel_done),
    .busy        (busy),
    .frame_done  (frame_done),
    .line_err    (line_err),
    .frame_cnt   (frame_cnt)
  );

  always #5 ap_clk = ~ap_clk;

  int   checks = 0;
  int   errors = 0;
  logic exp_lerr;
  int   exp_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] exp_addr(input int i);
    return {3'(i / 4), 3'(i % 4)};
  endfunction

  // Drives beats first..last_n-1 and checks each write on the following cycle.
  task automatic stream(input logic [7:0] base, input int first, input int last_n,
                        input bit gaps, input bit bad);
    int k       = first;
    int pend    = -1;
    bit started = 1'b0;
    while (k < last_n || pend >= 0) begin
      @(negedge ap_clk);
      if (pend >= 0) begin
        if (bad && pend == 1) exp_lerr = 1'b1;
        chk("wr_ce", 32'(mem_ce0), 1);
        chk("wr_we", 32'(mem_we0), 1);
        chk("wr_addr", 32'(mem_address0), 32'(exp_addr(pend)));
        chk("wr_data", 32'(mem_d0), 32'(base + 8'(pend)));
        chk("line_err", 32'(line_err), 32'(exp_lerr));
      end else if (started) begin
        chk("gap_ce", 32'(mem_ce0), 0);
        chk("gap_we", 32'(mem_we0), 0);
      end
      pend = -1;
      if (k < last_n && (!gaps || $urandom_range(1) == 1)) begin
        chk("tready", 32'(s_if.tready), 1);
        s_if.tvalid = 1'b1;
        s_if.tdata  = base + 8'(k);
        s_if.tlast  = bad ? (k == 1) : (k % 4 == 3);
        pend        = k;
        k++;
        started = 1'b1;
      end else begin
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
      end
    end
  endtask

  task automatic run_sobel(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge ap_clk);
      chk("start_hold", 32'(sobel_start), 1);
      chk("tready_run", 32'(s_if.tready), 0);
      chk("fdone_run", 32'(frame_done), 0);
    end
    sobel_done = 1'b1;
    @(negedge ap_clk);
    sobel_done = 1'b0;
    exp_cnt++;
    chk("frame_done", 32'(frame_done), 1);
    chk("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    chk("start_done", 32'(sobel_start), 0);
    @(negedge ap_clk);
    chk("fdone_pulse", 32'(frame_done), 0);
    chk("tready_idle", 32'(s_if.tready), 1);
    chk("busy_idle", 32'(busy), 0);
    chk("frame_cnt_hold", 32'(frame_cnt), 32'(exp_cnt));
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_tready"}, 32'(s_if.tready), 0);
    chk({tag, "_ce"}, 32'(mem_ce0), 0);
    chk({tag, "_we"}, 32'(mem_we0), 0);
    chk({tag, "_start"}, 32'(sobel_start), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_fdone"}, 32'(frame_done), 0);
    chk({tag, "_lerr"}, 32'(line_err), 0);
    chk({tag, "_cnt"}, 32'(frame_cnt), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    ap_rst      = 1'b1;
    sobel_done  = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = 8'h00;
    s_if.tlast  = 1'b0;
    exp_lerr    = 1'b0;
    exp_cnt     = 0;
    #1;
    reset_checks("rst");
    chk("rst_addr", 32'(mem_address0), 0);
    chk("rst_data", 32'(mem_d0), 0);
    @(negedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b0;

    // Back-to-back frame, then a long RUN phase.
    stream(8'h10, 0, 8, 1'b0, 1'b0);
    chk("start_rise", 32'(sobel_start), 1);
    chk("busy_run", 32'(busy), 1);
    chk("tready_run0", 32'(s_if.tready), 0);
    run_sobel(20);

    // sobel_done in IDLE is ignored.
    @(negedge ap_clk);
    sobel_done = 1'b1;
    @(negedge ap_clk);
    sobel_done = 1'b0;
    chk("idle_done_busy", 32'(busy), 0);
    chk("idle_done_fdone", 32'(frame_done), 0);
    chk("idle_done_cnt", 32'(frame_cnt), 32'(exp_cnt));

    // sobel_done in LOAD is ignored and the frame continues.
    stream(8'h30, 0, 3, 1'b0, 1'b0);
    sobel_done = 1'b1;
    @(negedge ap_clk);
    sobel_done = 1'b0;
    chk("load_done_busy", 32'(busy), 1);
    chk("load_done_start", 32'(sobel_start), 0);
    chk("load_done_fdone", 32'(frame_done), 0);
    chk("load_done_tready", 32'(s_if.tready), 1);
    chk("load_done_cnt", 32'(frame_cnt), 32'(exp_cnt));
    stream(8'h30, 3, 8, 1'b0, 1'b0);
    chk("start_rise2", 32'(sobel_start), 1);
    run_sobel(3);

    // Random valid gaps.
    stream(8'h10, 0, 8, 1'b1, 1'b0);
    chk("start_rise3", 32'(sobel_start), 1);
    run_sobel(4);

    // Misplaced tlast sets a sticky error without disturbing addressing.
    stream(8'h50, 0, 8, 1'b0, 1'b1);
    run_sobel(2);
    chk("lerr_sticky", 32'(line_err), 1);

    // Reset mid-frame discards the partial frame.
    stream(8'h60, 0, 5, 1'b0, 1'b0);
    ap_rst = 1'b1;
    #1;
    reset_checks("midrst");
    exp_cnt  = 0;
    exp_lerr = 1'b0;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    stream(8'hA0, 0, 8, 1'b0, 1'b0);
    run_sobel(5);
    chk("cnt_after_rst", 32'(frame_cnt), 1);

    // Reset during RUN drops sobel_start immediately.
    stream(8'hB0, 0, 8, 1'b0, 1'b0);
    chk("start_rise4", 32'(sobel_start), 1);
    ap_rst = 1'b1;
    #1;
    reset_checks("runrst");
    @(negedge ap_clk);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    chk("post_rst_tready", 32'(s_if.tready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
